// File: rtl/signal_narrowing.sv
// Narrows signed NB_EXTENDED_DATA-bit results to signed NB_DATA-bit words (saturate or wrap)
// behind a one-deep registered valid/ready stage, with sticky overflow flag and event counter.
module signal_narrowing #(
    parameter int NB_DATA          = 11,
    parameter int NB_EXTENDED_DATA = 16,
    parameter int NB_COUNT         = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [NB_EXTENDED_DATA-1:0] i_data,
    input  logic                        i_sat_mode,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [NB_DATA-1:0]          o_data,
    output logic                        o_overflow,
    output logic                        o_sticky_overflow,
    input  logic                        i_clear_flags,
    output logic [NB_COUNT-1:0]         o_overflow_count
);

    // Bits that must all match the output sign bit for the value to fit.
    localparam int NB_TOP = NB_EXTENDED_DATA - NB_DATA + 1;

    localparam logic signed [NB_DATA-1:0] MAX_VAL = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam logic signed [NB_DATA-1:0] MIN_VAL = {1'b1, {(NB_DATA-1){1'b0}}};
    localparam logic [NB_COUNT-1:0]       CNT_MAX = {NB_COUNT{1'b1}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic is_out_of_range(input logic signed [NB_EXTENDED_DATA-1:0] din);
        logic [NB_TOP-1:0] top;
        top = din[NB_EXTENDED_DATA-1 -: NB_TOP];
        return (|top) && !(&top);
    endfunction

    function automatic logic signed [NB_DATA-1:0] narrow(
        input logic signed [NB_EXTENDED_DATA-1:0] din,
        input logic                               sat_mode
    );
        logic signed [NB_DATA-1:0] res;
        res = din[NB_DATA-1:0];
        if (sat_mode && is_out_of_range(din)) begin
            res = din[NB_EXTENDED_DATA-1] ? MIN_VAL : MAX_VAL;
        end
        return res;
    endfunction

    state_t                    state_q, state_d;
    logic signed [NB_DATA-1:0] data_q, data_d;
    logic                      overflow_q, overflow_d;
    logic                      sticky_q, sticky_d;
    logic [NB_COUNT-1:0]       count_q, count_d;

    logic                             accept;
    logic                             emit;
    logic                             in_oor;
    logic signed [NB_EXTENDED_DATA-1:0] in_data;

    assign in_data = i_data;
    assign in_oor  = is_out_of_range(in_data);
    assign o_valid = (state_q == FULL);
    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;
    assign emit    = o_valid && i_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (emit && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        data_d     = data_q;
        overflow_d = overflow_q;
        if (accept) begin
            data_d     = narrow(in_data, i_sat_mode);
            overflow_d = in_oor;
        end
    end

    // Clear is applied before the event so a coinciding overflow still counts once.
    always_comb begin
        sticky_d = i_clear_flags ? 1'b0 : sticky_q;
        count_d  = i_clear_flags ? '0 : count_q;
        if (accept && in_oor) begin
            sticky_d = 1'b1;
            if (count_d != CNT_MAX) begin
                count_d = count_d + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= EMPTY;
            data_q     <= '0;
            overflow_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    assign o_data            = data_q;
    assign o_overflow        = overflow_q;
    assign o_sticky_overflow = sticky_q;
    assign o_overflow_count  = count_q;

endmodule

// File: tb/tb_signal_narrowing.sv
// Directed bench for signal_narrowing: arithmetic reference model checked every cycle,
// plus literal expectations along the directed sequence.
module tb_signal_narrowing;

    localparam int NB_DATA          = 11;
    localparam int NB_EXTENDED_DATA = 16;
    localparam int NB_COUNT         = 2;
    localparam int OMAX             = 1023;
    localparam int OMIN             = -1024;
    localparam int CMAX             = 3;

    logic                        i_clock = 1'b0;
    logic                        i_reset = 1'b0;
    logic                        i_valid = 1'b0;
    logic                        o_ready;
    logic [NB_EXTENDED_DATA-1:0] i_data = '0;
    logic                        i_sat_mode = 1'b0;
    logic                        o_valid;
    logic                        i_ready = 1'b0;
    logic [NB_DATA-1:0]          o_data;
    logic                        o_overflow;
    logic                        o_sticky_overflow;
    logic                        i_clear_flags = 1'b0;
    logic [NB_COUNT-1:0]         o_overflow_count;

    signal_narrowing #(
        .NB_DATA(NB_DATA), .NB_EXTENDED_DATA(NB_EXTENDED_DATA), .NB_COUNT(NB_COUNT)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_sat_mode(i_sat_mode), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_overflow(o_overflow), .o_sticky_overflow(o_sticky_overflow),
        .i_clear_flags(i_clear_flags), .o_overflow_count(o_overflow_count)
    );

    always #5 i_clock = ~i_clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: integer arithmetic on the range rules.
    function automatic int model_value(input int v, input bit sat);
        int w;
        if (sat && v > OMAX) return OMAX;
        if (sat && v < OMIN) return OMIN;
        w = v % 2048;
        if (w < 0) w += 2048;
        if (w >= 1024) w -= 2048;
        return w;
    endfunction

    bit m_valid = 0, m_ovf = 0, m_sticky = 0, started = 0;
    int m_data = 0, m_count = 0;
    bit acc, oor, st;
    int v, cnt;

    always @(posedge i_clock) begin
        started <= 1'b1;
        if (!i_reset) begin
            m_valid <= 0; m_data <= 0; m_ovf <= 0; m_sticky <= 0; m_count <= 0;
        end else begin
            v   = int'($signed(i_data));
            oor = (v > OMAX) || (v < OMIN);
            acc = i_valid && (!m_valid || i_ready);
            if (acc) begin
                m_valid <= 1; m_data <= model_value(v, i_sat_mode); m_ovf <= oor;
            end else if (i_ready) begin
                m_valid <= 0;
            end
            cnt = i_clear_flags ? 0 : m_count;
            st  = i_clear_flags ? 1'b0 : m_sticky;
            if (acc && oor) begin
                st = 1'b1;
                if (cnt < CMAX) cnt++;
            end
            m_count  <= cnt;
            m_sticky <= st;
        end
    end

    logic [NB_DATA-1:0] m_data_bits;
    assign m_data_bits = m_data[NB_DATA-1:0];

    always @(negedge i_clock) begin
        if (started) begin
            chk("model_valid", 32'(o_valid), 32'(m_valid));
            chk("model_ready", 32'(o_ready), 32'(!m_valid || i_ready));
            chk("model_sticky", 32'(o_sticky_overflow), 32'(m_sticky));
            chk("model_count", 32'(o_overflow_count), 32'(m_count));
            if (m_valid || !i_reset) begin
                chk("model_data", 32'(o_data), 32'(m_data_bits));
                chk("model_ovf", 32'(o_overflow), 32'(m_ovf));
            end
        end
    end

    task automatic cyc(input bit vld, input int d, input bit sat, input bit rdy, input bit clr);
        i_valid = vld; i_data = d[NB_EXTENDED_DATA-1:0]; i_sat_mode = sat;
        i_ready = rdy; i_clear_flags = clr;
        @(posedge i_clock);
        #1;
    endtask

    task automatic lit(input string name, input logic [NB_DATA-1:0] d, input bit ovf);
        chk({name, "_valid"}, 32'(o_valid), 32'd1);
        chk({name, "_data"}, 32'(o_data), 32'(d));
        chk({name, "_ovf"}, 32'(o_overflow), 32'(ovf));
    endtask

    int tbl_d[8]   = '{300, -1500, 1024, -1025, 0, 32767, -32768, 511};
    bit tbl_s[8]   = '{1, 0, 1, 0, 1, 0, 1, 0};
    bit tbl_r[8]   = '{1, 0, 1, 1, 0, 0, 1, 1};

    initial begin
        i_reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_count", 32'(o_overflow_count), 32'd0);
        chk("rst_sticky", 32'(o_sticky_overflow), 32'd0);
        i_reset = 1'b1;

        cyc(1, 25, 1, 1, 0);      lit("pos25", 11'h019, 0);
        cyc(1, -25, 1, 1, 0);     lit("neg25", 11'h7E7, 0);
        cyc(1, 2000, 1, 1, 0);    lit("sat_hi", 11'h3FF, 1);
        cyc(1, -5000, 1, 1, 0);   lit("sat_lo", 11'h400, 1);
        chk("sat_sticky", 32'(o_sticky_overflow), 32'd1);
        chk("sat_count", 32'(o_overflow_count), 32'd2);
        cyc(1, 2000, 0, 1, 0);    lit("wrap", 11'h7D0, 1);
        chk("wrap_count", 32'(o_overflow_count), 32'd3);
        cyc(1, 1023, 0, 1, 0);    lit("bound_max", 11'h3FF, 0);
        cyc(1, -1024, 0, 1, 0);   lit("bound_min", 11'h400, 0);
        cyc(1, 30000, 1, 1, 0);
        cyc(1, -30000, 0, 1, 0);
        chk("count_sat", 32'(o_overflow_count), 32'd3);

        cyc(0, 0, 0, 1, 1);
        chk("clr_count", 32'(o_overflow_count), 32'd0);
        chk("clr_sticky", 32'(o_sticky_overflow), 32'd0);
        chk("drain_valid", 32'(o_valid), 32'd0);
        cyc(1, -3000, 1, 1, 1);   lit("clr_ovf", 11'h400, 1);
        chk("clr_ev_count", 32'(o_overflow_count), 32'd1);
        chk("clr_ev_sticky", 32'(o_sticky_overflow), 32'd1);

        for (int k = 0; k < 5; k++) begin
            cyc(1, 100, 1, 0, 0);
            chk("bp_ready", 32'(o_ready), 32'd0);
            lit("bp_hold", 11'h400, 1);
        end
        cyc(1, 100, 1, 1, 0);     lit("b2b0", 11'h064, 0);
        cyc(1, 101, 1, 1, 0);     lit("b2b1", 11'h065, 0);
        cyc(1, 102, 1, 1, 0);     lit("b2b2", 11'h066, 0);

        for (int k = 0; k < 8; k++) cyc(1, tbl_d[k], tbl_s[k], tbl_r[k], 0);
        cyc(0, 0, 0, 1, 0);

        cyc(1, 200, 1, 0, 0);
        cyc(1, 5000, 1, 0, 0);
        i_reset = 1'b0;
        cyc(1, 5000, 1, 0, 0);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_data", 32'(o_data), 32'd0);
        chk("mid_rst_count", 32'(o_overflow_count), 32'd0);
        chk("mid_rst_sticky", 32'(o_sticky_overflow), 32'd0);
        i_reset = 1'b1;
        cyc(1, -7, 1, 1, 0);      lit("post_rst", 11'h7F9, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signal_narrowing.md
Name: signal_narrowing

Overview:
Inverse of the immediate sign-extension path. Takes signed NB_EXTENDED_DATA-bit datapath results (e.g. accumulator values) and narrows them to signed NB_DATA-bit words for the narrow operand/memory side. The result is either saturated or two's-complement wrapped. One registered output stage with a valid/ready handshake. Keeps a sticky overflow flag and a saturating overflow-event counter for debug readout.

Parameters:
NB_DATA, 11, width of narrowed signed output
NB_EXTENDED_DATA, 16, width of signed input; must be >= NB_DATA
NB_COUNT, 8, width of overflow-event counter

Ports:
i_clock  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-low reset
i_valid  input  1  input word present
o_ready  output 1  block can accept input this cycle
i_data  input  NB_EXTENDED_DATA  signed value to narrow
i_sat_mode  input  1  1 = saturate, 0 = wrap (truncate MSBs); sampled with the accepted word
o_valid  output 1  output register holds a word
i_ready  input  1  downstream accepts output this cycle
o_data  output NB_DATA  narrowed signed value
o_overflow  output 1  registered per-word flag: the held word was out of range
o_sticky_overflow  output 1  set on any accepted out-of-range word
i_clear_flags  input  1  clears sticky flag and counter
o_overflow_count  output NB_COUNT  number of accepted out-of-range words, saturates at all-ones

Behaviour:
- Reset (i_reset==0 at clock edge): o_valid=0, o_data=0, o_overflow=0, o_sticky_overflow=0, o_overflow_count=0. Reset mid-transfer drops the held word with no handshake.
- o_ready = !o_valid || i_ready (combinational). Accept = i_valid && o_ready. Emit = o_valid && i_ready.
- On accept, the output register loads next cycle. Latency: 1 clock from accept to o_valid=1.
- Accept and emit in the same cycle: full throughput, one word per clock, no bubble.
- Emit without accept: o_valid goes to 0. No accept and no emit: o_data, o_overflow and o_valid hold. o_data is stable while o_valid && !i_ready.
- Range: MAX = 2^(NB_DATA-1)-1, MIN = -2^(NB_DATA-1). Defaults: 1023 and -1024.
- Out-of-range: i_data bits [NB_EXTENDED_DATA-1:NB_DATA-1] are not all equal.
- In range: o_data = i_data[NB_DATA-1:0] in both modes, and o_overflow=0.
- Out of range, i_sat_mode=1: o_data = MAX if i_data is positive, MIN if negative.
- Out of range, i_sat_mode=0: o_data = i_data[NB_DATA-1:0].
- o_overflow=1 for any out-of-range word, in either mode.
- NB_EXTENDED_DATA==NB_DATA: never out of range; the block acts as a pass-through register.
- Sticky flag and counter update only on accepted out-of-range words. The counter holds at 2^NB_COUNT-1.
- i_clear_flags alone: sticky flag=0 and count=0 next cycle.
- i_clear_flags in the same cycle as an accepted out-of-range word: sticky=1 and count=1 next cycle (clear first, then the event applies).
- Output states: EMPTY (o_valid=0) and FULL (o_valid=1).
  - EMPTY goes to FULL on accept.
  - FULL stays FULL on accept with emit, or on no emit.
  - FULL goes to EMPTY on emit without accept.

Test Plan:
- Reset, then i_data=25, sat=1, i_ready=1 -> 1 clock later o_valid=1, o_data=11'h019, o_overflow=0. Then i_data=-25 -> o_data=11'h7E7, o_overflow=0.
- Saturate mode: i_data=2000 -> o_data=11'h3FF (1023). Then i_data=-5000 -> o_data=11'h400 (-1024). o_overflow=1 on both, o_sticky_overflow=1, o_overflow_count=2.
- Wrap mode: i_data=2000 (16'h07D0) -> o_data=11'h7D0, o_overflow=1, count increments. Boundaries 1023 and -1024 -> passed unchanged, o_overflow=0.
- Backpressure: i_ready=0 while o_valid=1 -> o_ready=0, o_data holds for 5 cycles. Raise i_ready together with i_valid -> back-to-back words emitted with no gap, none lost or duplicated.
- NB_COUNT=2: feed 5 out-of-range words -> count stays at 3. Pulse i_clear_flags -> 0. Clear coinciding with an overflow word -> count=1, sticky=1.
- Drive i_reset=0 while o_valid=1 and i_ready=0 -> next cycle o_valid=0, o_data=0, flags and count=0. A word presented after release is accepted normally.
